comb_row_writer: RTL and testbench

Combination-stage sequencer for the GCN datapath: computes each output row as the sum of FM×WM rows selected by the binary adjacency row. It writes that row into the combination result buffer. After the last row it raises a sticky `done_comb`, which the argmax stage consumes as its start condition. This block is the producer side of the `done_comb` / row-buffer interface that the argmax stage reads.

---
 rtl/comb_row_writer.sv | 126 ++++++++++++
 tb/tb_comb_row_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/comb_row_writer.sv
// Combination-stage sequencer: each output row is the sum of the FM x WM rows
// selected by the matching adjacency row, written once per row, then a sticky done.

module comb_acc_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  add,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]  acc
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= acc + ACC_WIDTH'($signed(din));
  end
endmodule

module comb_row_writer #(
  parameter int ROWS       = 6,
  parameter int FEATS      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(ROWS),
  parameter int ROW_WIDTH  = $clog2(ROWS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [ROW_WIDTH-1:0]        adj_addr,
  input  logic [ROWS-1:0]             adj_rd_data,
  output logic [ROW_WIDTH-1:0]        fmwm_addr,
  input  logic [FEATS*DATA_WIDTH-1:0] fmwm_rd_data,
  output logic                        wr_en,
  output logic [ROW_WIDTH-1:0]        wr_addr,
  output logic [FEATS*ACC_WIDTH-1:0]  wr_data,
  output logic                        done_comb,
  output logic                        is_idle,
  output logic                        is_busy,
  output logic                        is_done
);
  typedef enum logic [2:0] {IDLE, READ_ADJ, READ_K, ACC_K, WRITE_ROW, DONE} state_t;

  localparam logic [ROW_WIDTH-1:0] LAST = ROW_WIDTH'(ROWS - 1);

  state_t                  state, state_n;
  logic [ROW_WIDTH-1:0]    row, k;
  logic [ROWS-1:0]         adj_reg;
  logic [FEATS-1:0][ACC_WIDTH-1:0] acc;
  logic                    acc_clr, acc_add;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    adj_addr  = '0;
    fmwm_addr = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    case (state)
      IDLE:      if (start) state_n = READ_ADJ;
      READ_ADJ: begin
        adj_addr = row;
        acc_clr  = 1'b1;
        state_n  = READ_K;
      end
      READ_K: begin
        fmwm_addr = k;
        state_n   = ACC_K;
      end
      ACC_K: begin
        acc_add = adj_reg[k];
        state_n = (k == LAST) ? WRITE_ROW : READ_K;
      end
      WRITE_ROW: begin
        wr_en   = 1'b1;
        wr_addr = row;
        state_n = (row == LAST) ? DONE : READ_ADJ;
      end
      DONE:      state_n = DONE;
      default:   state_n = IDLE;
    endcase
  end

  // Adjacency word arrives one cycle after READ_ADJ, i.e. during the k==0 READ_K.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row     <= '0;
      k       <= '0;
      adj_reg <= '0;
    end else begin
      case (state)
        IDLE:      if (start) row <= '0;
        READ_ADJ:  k <= '0;
        READ_K:    if (k == '0) adj_reg <= adj_rd_data;
        ACC_K:     if (k != LAST) k <= k + ROW_WIDTH'(1);
        WRITE_ROW: if (row != LAST) row <= row + ROW_WIDTH'(1);
        default:   ;
      endcase
    end
  end

  for (genvar f = 0; f < FEATS; f++) begin : g_lane
    comb_acc_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .add   (acc_add),
      .din   (fmwm_rd_data[f*DATA_WIDTH +: DATA_WIDTH]),
      .acc   (acc[f])
    );
  end

  assign wr_data   = acc;
  assign done_comb = (state == DONE);
  assign is_done   = (state == DONE);
  assign is_idle   = (state == IDLE);
  assign is_busy   = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_comb_row_writer.sv
// Directed bench for comb_row_writer: memory models, write scoreboard, timing checks.

module tb_comb_row_writer;
  localparam int ROWS = 6, FEATS = 3, DW = 16, AW = DW + $clog2(ROWS), RW = $clog2(ROWS);

  logic                 clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [RW-1:0]        adj_addr, fmwm_addr, wr_addr;
  logic [ROWS-1:0]      adj_rd_data = '0;
  logic [FEATS*DW-1:0]  fmwm_rd_data = '0;
  logic                 wr_en, done_comb, is_idle, is_busy, is_done;
  logic [FEATS*AW-1:0]  wr_data;

  comb_row_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .adj_addr(adj_addr), .adj_rd_data(adj_rd_data),
    .fmwm_addr(fmwm_addr), .fmwm_rd_data(fmwm_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done_comb(done_comb), .is_idle(is_idle), .is_busy(is_busy), .is_done(is_done)
  );

  always #5 clk = ~clk;

  logic [ROWS-1:0]     adj_mem  [ROWS];
  logic [FEATS*DW-1:0] fmwm_mem [ROWS];
  int fm_val [ROWS][FEATS];

  // One-cycle-latency synchronous read memories.
  always @(posedge clk) begin
    adj_rd_data  <= adj_mem[adj_addr];
    fmwm_rd_data <= fmwm_mem[fmwm_addr];
  end

  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [63:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, wcount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_acc(input int a, input int b, input int c);
    logic [FEATS*AW-1:0] v;
    v[0*AW +: AW] = AW'(a);
    v[1*AW +: AW] = AW'(b);
    v[2*AW +: AW] = AW'(c);
    return 64'(v);
  endfunction

  function automatic logic [63:0] model_row(input int r);
    int s [FEATS];
    for (int f = 0; f < FEATS; f++) s[f] = 0;
    for (int kk = 0; kk < ROWS; kk++)
      if (adj_mem[r][kk])
        for (int f = 0; f < FEATS; f++) s[f] += fm_val[kk][f];
    return pack_acc(s[0], s[1], s[2]);
  endfunction

  task automatic set_fm(input int r, input int a, input int b, input int c);
    fm_val[r][0] = a; fm_val[r][1] = b; fm_val[r][2] = c;
    fmwm_mem[r] = {DW'(c), DW'(b), DW'(a)};
  endtask

  task automatic push(input int r, input logic [63:0] d);
    exp_t e;
    e.addr = r; e.data = d; e.cyc = t0 + (2*ROWS + 2) * r + 2*ROWS + 2;
    sb.push_back(e);
  endtask

  // Scoreboard: every write pulse must match the next expected row, data and cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wcount++;
      if (sb.size() == 0) begin
        check("unexpected_wr", 64'(wr_addr), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), e.data);
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_idle", 64'(is_idle), 64'd1);
    check("rst_flags", 64'({done_comb, wr_en, is_busy, is_done}), 64'd0);
    check("rst_addrs", 64'({adj_addr, fmwm_addr, wr_addr}), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    reset = 1'b1;
    sb.delete();
    wcount = 0;
    @(negedge clk);
  endtask

  task automatic begin_start();
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_comb !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_comb), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc - t0), 64'(ROWS * (2*ROWS + 2) + 1));
    check({tag, "_is_done"}, 64'({is_done, is_busy, is_idle}), 64'b100);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_wcount"}, 64'(wcount), 64'(ROWS));
  endtask

  task automatic load_identity();
    for (int r = 0; r < ROWS; r++) begin
      adj_mem[r] = ROWS'(1) << r;
      set_fm(r, r, 2*r, -r);
    end
  endtask

  task automatic run_identity(input string tag);
    @(negedge clk);
    begin_start();
    for (int r = 0; r < ROWS; r++) push(r, pack_acc(r, 2*r, -r));
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin adj_mem[r] = '0; set_fm(r, 0, 0, 0); end
    repeat (2) @(negedge clk);
    do_reset();

    // Identity adjacency: rows pass straight through.
    load_identity();
    run_identity("ident");

    // All-ones adjacency with maximal positive data.
    do_reset();
    for (int r = 0; r < ROWS; r++) begin adj_mem[r] = '1; set_fm(r, 32767, 32767, 32767); end
    @(negedge clk);
    begin_start();
    for (int r = 0; r < ROWS; r++) push(r, pack_acc(196602, 196602, 196602));
    @(negedge clk);
    start = 1'b0;
    wait_done("ones");

    // Negative data on row 0, identity elsewhere.
    do_reset();
    load_identity();
    adj_mem[0] = 6'b000011;
    set_fm(0, -32768, -1, 5);
    set_fm(1, -32768, -1, -5);
    @(negedge clk);
    begin_start();
    push(0, pack_acc(-65536, -2, 0));
    for (int r = 1; r < ROWS; r++) push(r, model_row(r));
    @(negedge clk);
    start = 1'b0;
    wait_done("neg");

    // Zero adjacency row 3.
    do_reset();
    load_identity();
    adj_mem[3] = '0;
    @(negedge clk);
    begin_start();
    for (int r = 0; r < ROWS; r++) push(r, (r == 3) ? pack_acc(0, 0, 0) : pack_acc(r, 2*r, -r));
    @(negedge clk);
    start = 1'b0;
    wait_done("zero3");

    // Reset in cycle 30: only rows 0 and 1 may be written.
    do_reset();
    load_identity();
    @(negedge clk);
    begin_start();
    push(0, pack_acc(0, 0, 0));
    push(1, pack_acc(1, 2, -1));
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 30) @(negedge clk);
    reset = 1'b0;
    check("midrst_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_idle", 64'(is_idle), 64'd1);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_wcount", 64'(wcount), 64'd2);
    check("midrst_stay_idle", 64'({is_idle, done_comb, is_busy}), 64'b100);
    wcount = 0;
    run_identity("replay");

    // Start held high for 300 cycles: one run only, DONE absorbing.
    do_reset();
    load_identity();
    @(negedge clk);
    begin_start();
    for (int r = 0; r < ROWS; r++) push(r, pack_acc(r, 2*r, -r));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cyc - t0 >= ROWS * (2*ROWS + 2) + 1)
        check("hold_done", 64'({done_comb, is_done, is_busy, is_idle}), 64'b1100);
    end
    check("hold_wcount", 64'(wcount), 64'(ROWS));
    check("hold_sb_empty", 64'(sb.size()), 64'd0);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
